pdm_stereo_deserializer: RTL and testbench

Parametrised successor to the single-bit PDM shifter. Generates the microphone PDM clock from the system clock and samples one shared PDM data line on both phases, giving two channels (left/right, ADMP-style LRSEL wiring). Each channel is deserialised into a WORD_W-bit word, and completed frames are presented with a valid/ready handshake and a sticky overflow flag. It sits between the microphone pins and the downstream PDM-to-PCM filter.

---
 rtl/pdm_pkg.sv | 23 ++
 rtl/pdm_stereo_deserializer_clk_gen.sv | 42 ++++
 rtl/pdm_stereo_deserializer.sv | 101 ++++++++++
 tb/tb_pdm_stereo_deserializer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared defaults, sizing helper and parameter sanity check for the PDM deserializer.
package pdm_pkg;

  localparam int unsigned PDM_WORD_W  = 32;
  localparam int unsigned PDM_CLK_DIV = 50;

  // Ceiling log2, never less than 1 so counters always have at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  function automatic bit params_ok(input int unsigned word_w, input int unsigned clk_div,
                                   input int unsigned channels);
    return (word_w >= 2) && (clk_div >= 4) && (clk_div % 2 == 0) &&
           (channels == 1 || channels == 2);
  endfunction

endpackage

// File: rtl/pdm_stereo_deserializer_clk_gen.sv
// PDM clock divider: registered pdm_clk plus strobes on the last cycle of each phase.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = PDM_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pdm_clk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned CW = clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF    = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_next;

  always_comb begin
    div_next = '0;
    if (en && div_cnt != LAST) div_next = div_cnt + CW'(1);
  end

  // pdm_clk is derived from the next count so it lines up with div_cnt in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pdm_clk <= (div_next >= HALF);
    end
  end

  assign rise_stb = en && (div_cnt == HALF_M1);
  assign fall_stb = en && (div_cnt == LAST);

endmodule

// File: rtl/pdm_stereo_deserializer.sv
// Two-channel PDM capture on one shared data line, framed into words with valid/ready handoff.
module pdm_stereo_deserializer
  import pdm_pkg::*;
#(
  parameter int unsigned WORD_W   = PDM_WORD_W,
  parameter int unsigned CLK_DIV  = PDM_CLK_DIV,
  parameter int unsigned CHANNELS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pdm_data,
  output logic              pdm_clk,
  output logic [WORD_W-1:0] word_l,
  output logic [WORD_W-1:0] word_r,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  input  logic              clear_ovf
);

  if (!params_ok(WORD_W, CLK_DIV, CHANNELS)) begin : g_bad_params
    $error("pdm_stereo_deserializer: illegal WORD_W/CLK_DIV/CHANNELS");
  end

  localparam int unsigned BW = clog2(WORD_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  logic              pdm_q;
  logic              rise_stb;
  logic              fall_stb;
  logic [WORD_W-1:0] shreg_l;
  logic [WORD_W-1:0] shreg_r;
  logic [WORD_W-1:0] shreg_l_next;
  logic [BW-1:0]     bit_cnt;
  logic              frame_done;
  logic              accept;
  logic              drop;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pdm_clk  (pdm_clk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign shreg_l_next = {shreg_l[WORD_W-2:0], pdm_q};
  assign frame_done   = fall_stb && (bit_cnt == BIT_LAST);
  assign accept       = frame_done && (!word_valid || word_ready);
  assign drop         = frame_done && word_valid && !word_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pdm_q   <= 1'b0;
      shreg_l <= '0;
      shreg_r <= '0;
      bit_cnt <= '0;
    end else begin
      pdm_q <= pdm_data;
      if (!en) begin
        shreg_l <= '0;
        shreg_r <= '0;
        bit_cnt <= '0;
      end else begin
        if (rise_stb && CHANNELS == 2) shreg_r <= {shreg_r[WORD_W-2:0], pdm_q};
        if (fall_stb) begin
          shreg_l <= shreg_l_next;
          bit_cnt <= frame_done ? '0 : bit_cnt + BW'(1);
        end
      end
    end
  end

  // Output frame and overflow survive en going low so a pending frame can still drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_l     <= '0;
      word_r     <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        word_l     <= shreg_l_next;
        word_r     <= shreg_r;
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_stereo_deserializer.sv
// Self-checking bench: table and random frames streamed bit-serially, plus handshake corner cases.
module tb_pdm_stereo_deserializer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FP = W * D;

  typedef struct {
    logic [W-1:0] l_bits;
    logic [W-1:0] r_bits;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         pdm_data;
  logic         pdm_clk;
  logic [W-1:0] word_l;
  logic [W-1:0] word_r;
  logic         word_valid;
  logic         word_ready;
  logic         overflow;
  logic         clear_ovf;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t frames[8];

  pdm_stereo_deserializer #(
    .WORD_W   (W),
    .CLK_DIV  (D),
    .CHANNELS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pdm_data   (pdm_data),
    .pdm_clk    (pdm_clk),
    .word_l     (word_l),
    .word_r     (word_r),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The microphone holds the right bit during the low phase and the left bit during the high
  // phase; each word collects its channel's bits oldest-first. With ready=1 every frame appears
  // for exactly one cycle at multiples of FP; with ready=0 the first frame is held and any later
  // completion raises overflow.
  task automatic stream(input int nframes, input bit ready);
    int k, j, s;
    for (int t = 0; t < nframes * FP; t++) begin
      k = t / FP;
      j = (t % FP) / D;
      en         = 1'b1;
      word_ready = ready;
      clear_ovf  = 1'b0;
      pdm_data   = ((t % D) < D / 2) ? frames[k].r_bits[W-1-j] : frames[k].l_bits[W-1-j];
      tick();
      s = t + 1;
      check("pdm_clk", 32'(pdm_clk), 32'((s % D) >= D / 2));
      if (ready) begin
        check("word_valid", 32'(word_valid), 32'(s % FP == 0));
        check("overflow", 32'(overflow), 32'd0);
        if (s % FP == 0) begin
          check("word_l", 32'(word_l), 32'(frames[s/FP-1].exp_l));
          check("word_r", 32'(word_r), 32'(frames[s/FP-1].exp_r));
        end
      end else begin
        check("held_valid", 32'(word_valid), 32'(s >= FP));
        check("held_overflow", 32'(overflow), 32'(s >= 2 * FP));
        if (s >= FP) begin
          check("held_word_l", 32'(word_l), 32'(frames[0].exp_l));
          check("held_word_r", 32'(word_r), 32'(frames[0].exp_r));
        end
      end
    end
  endtask

  initial begin
    logic [W-1:0] rnd_l, rnd_r;

    // Reset with enable and data active
    rst_n      = 1'b0;
    en         = 1'b1;
    pdm_data   = 1'b1;
    word_ready = 1'b0;
    clear_ovf  = 1'b0;
    repeat (3) tick();
    check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
    check("rst_word_l", 32'(word_l), 32'd0);
    check("rst_word_r", 32'(word_r), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    en    = 1'b0;
    tick();

    // Table vectors followed by random frames, streamed back to back
    frames[0] = '{l_bits: 8'hFF, r_bits: 8'hFF, exp_l: 8'hFF, exp_r: 8'hFF};
    frames[1] = '{l_bits: 8'hFF, r_bits: 8'h00, exp_l: 8'hFF, exp_r: 8'h00};
    frames[2] = '{l_bits: 8'hA5, r_bits: 8'h5A, exp_l: 8'hA5, exp_r: 8'h5A};
    for (int i = 3; i < 8; i++) begin
      rnd_l     = 8'($urandom);
      rnd_r     = 8'($urandom);
      frames[i] = '{l_bits: rnd_l, r_bits: rnd_r, exp_l: rnd_l, exp_r: rnd_r};
    end
    stream(8, 1'b1);
    en = 1'b0;
    tick();
    check("valid_after_accept", 32'(word_valid), 32'd0);

    // Backpressure: second frame is dropped and flagged
    for (int i = 0; i < 2; i++) begin
      rnd_l     = 8'($urandom);
      rnd_r     = 8'($urandom);
      frames[i] = '{l_bits: rnd_l, r_bits: rnd_r, exp_l: rnd_l, exp_r: rnd_r};
    end
    stream(2, 1'b0);
    en         = 1'b0;
    word_ready = 1'b0;
    clear_ovf  = 1'b1;
    tick();
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("valid_kept_disabled", 32'(word_valid), 32'd1);
    check("word_kept_disabled", 32'(word_l), 32'(frames[0].exp_l));
    clear_ovf  = 1'b0;
    word_ready = 1'b1;
    tick();
    check("valid_drained", 32'(word_valid), 32'd0);

    // Abort after three left bits, then restart cleanly
    for (int t = 0; t < 3 * D; t++) begin
      en       = 1'b1;
      pdm_data = 1'($urandom);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      en = 1'b0;
      tick();
      check("dis_pdm_clk", 32'(pdm_clk), 32'd0);
      check("dis_valid", 32'(word_valid), 32'd0);
    end
    frames[0] = '{l_bits: 8'hC3, r_bits: 8'h3C, exp_l: 8'hC3, exp_r: 8'h3C};
    stream(1, 1'b1);
    en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
